// File: rtl/l2_flatten.sv
// Layer-2 flatten: reads the two 32x32 layer-1 pool maps and writes them
// interleaved (k0 at even, k1 at odd addresses) into the layer-2 memory.
module l2_flatten #(
  parameter int         N_PIX  = 1024,
  parameter logic [2:0] SEL_K0 = 3'b011,
  parameter logic [2:0] SEL_K1 = 3'b100,
  parameter logic [2:0] SEL_L2 = 3'b101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic [2:0]  csel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [10:0] J_LAST = 11'(2 * N_PIX - 1);

  state_t      state_reg, state_next;
  logic [10:0] j_reg, j_next;
  logic [19:0] data_reg, data_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      j_reg     <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      j_reg     <= j_next;
      data_reg  <= data_next;
    end
  end

  // j[0] selects the kernel, j[10:1] the element, so the write address is j itself.
  always_comb begin
    state_next = state_reg;
    j_next     = j_reg;
    data_next  = data_reg;
    busy       = (state_reg != S_IDLE);
    done       = 1'b0;
    crd        = 1'b0;
    cwr        = 1'b0;
    csel       = 3'b000;
    caddr_rd   = 12'h000;
    caddr_wr   = {1'b0, j_reg};
    cdata_wr   = data_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_RD;
          j_next     = '0;
        end
      end
      S_RD: begin
        crd        = 1'b1;
        csel       = j_reg[0] ? SEL_K1 : SEL_K0;
        caddr_rd   = {2'b00, j_reg[10:1]};
        state_next = S_CAP;
      end
      S_CAP: begin
        csel       = j_reg[0] ? SEL_K1 : SEL_K0;
        caddr_rd   = {2'b00, j_reg[10:1]};
        data_next  = cdata_rd;
        state_next = S_WR;
      end
      S_WR: begin
        cwr  = 1'b1;
        csel = SEL_L2;
        if (j_reg == J_LAST) begin
          state_next = S_DONE;
        end else begin
          j_next     = j_reg + 11'd1;
          state_next = S_RD;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_l2_flatten.sv
// Directed bench for l2_flatten: bus memory model, cycle-accurate protocol
// monitor and hand-computed checks of reset, full runs, abort and restart.
module tb_l2_flatten;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, crd, cwr;
  logic [11:0] caddr_rd, caddr_wr;
  logic [19:0] cdata_rd, cdata_wr;
  logic [2:0]  csel;

  l2_flatten dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Memory model: registered read, write committed at the clock edge.
  logic [19:0] mem_k0 [1024];
  logic [19:0] mem_k1 [1024];
  logic [19:0] mem_l2 [2048];

  always @(posedge clk) begin
    if (crd) begin
      if (csel == 3'd3)      cdata_rd <= mem_k0[caddr_rd[9:0]];
      else if (csel == 3'd4) cdata_rd <= mem_k1[caddr_rd[9:0]];
      else                   cdata_rd <= 20'hBAD00;
    end
    if (cwr && csel == 3'd5) mem_l2[caddr_wr[10:0]] <= cdata_wr;
  end

  function automatic logic [19:0] exp_data(input int jj);
    int i;
    i = jj / 2;
    return (jj % 2 != 0) ? (20'hF0000 + 20'(i)) : 20'(i);
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: expected bus behaviour derived from the cycle number since start.
  int          base   = 0;
  bit          mon_en = 1'b0;
  int          proto_err = 0, stray = 0, n_rd = 0, n_wr = 0, n_done = 0;
  int          acc_n = 0;
  logic [31:0] acc_wr [3];
  logic [31:0] acc_sel [3];
  logic [31:0] acc_addr [3];

  initial begin
    forever begin
      int rel, jj;
      bit exp_rd, exp_cap, exp_wr;
      @(negedge clk);
      if (crd === 1'b1 && cwr === 1'b1) proto_err++;
      if ((crd === 1'b1 || cwr === 1'b1) && acc_n < 3) begin
        acc_wr[acc_n]   = (cwr === 1'b1) ? 32'd1 : 32'd0;
        acc_sel[acc_n]  = 32'(csel);
        acc_addr[acc_n] = (cwr === 1'b1) ? 32'(caddr_wr) : 32'(caddr_rd);
        acc_n++;
      end
      if (crd === 1'b1)  n_rd++;
      if (cwr === 1'b1)  n_wr++;
      if (done === 1'b1) n_done++;
      if (!mon_en) begin
        if (crd === 1'b1 || cwr === 1'b1 || done === 1'b1 || busy === 1'b1) stray++;
      end else begin
        rel     = cyc - base;
        exp_rd  = (rel >= 1 && rel <= 6142 && rel % 3 == 1);
        exp_cap = (rel >= 2 && rel <= 6143 && rel % 3 == 2);
        exp_wr  = (rel >= 3 && rel <= 6144 && rel % 3 == 0);
        if (crd !== exp_rd) proto_err++;
        if (cwr !== exp_wr) proto_err++;
        if (done !== (rel == 6145)) proto_err++;
        if (busy !== (rel >= 1 && rel <= 6145)) proto_err++;
        if (exp_rd || exp_cap) begin
          jj = exp_rd ? (rel - 1) / 3 : (rel - 2) / 3;
          if (csel !== ((jj % 2 != 0) ? 3'd4 : 3'd3) || caddr_rd !== 12'(jj / 2)) proto_err++;
        end
        if (exp_wr) begin
          jj = (rel - 3) / 3;
          if (csel !== 3'd5 || caddr_wr !== 12'(jj) || cdata_wr !== exp_data(jj)) proto_err++;
        end
        if ((rel < 1 || rel >= 6145) && csel !== 3'd0) proto_err++;
      end
    end
  end

  task automatic check_l2(input string tag);
    int e = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem_l2[2*i]   !== 20'(i))             e++;
      if (mem_l2[2*i+1] !== 20'hF0000 + 20'(i)) e++;
    end
    check(tag, e, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_crd"},   crd, 0);
    check({tag, "_cwr"},   cwr, 0);
    check({tag, "_csel"},  csel, 0);
    check({tag, "_caddr_rd"}, caddr_rd, 0);
    check({tag, "_caddr_wr"}, caddr_wr, 0);
    check({tag, "_cdata_wr"}, cdata_wr, 0);
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int w0, r0, d0, pe0, s0;
    for (int i = 0; i < 1024; i++) begin
      mem_k0[i] = 20'(i);
      mem_k1[i] = 20'hF0000 + 20'(i);
    end

    // Reset held with start high: nothing may move.
    reset = 1'b0;
    start = 1'b1;
    repeat (3) step();
    check_zero_outputs("reset");
    check("reset_no_strobes", stray, 0);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) step();
    check("idle_busy", busy, 0);
    check("idle_csel", csel, 0);

    // Run 1 with start pulses while busy and in DONE.
    w0 = n_wr; r0 = n_rd; d0 = n_done; pe0 = proto_err;
    base = cyc; mon_en = 1'b1; start = 1'b1;
    for (int n = 1; n <= 6147; n++) begin
      step();
      start = (n == 10 || n == 3000 || n == 6145);
      if (n == 1)    check("run1_busy_c1", busy, 1);
      if (n == 3)    check("run1_first_wr_addr", {cwr, caddr_wr}, {1'b1, 12'h000});
      if (n == 6144) check("run1_last_wr_addr", {cwr, caddr_wr}, {1'b1, 12'h7FF});
      if (n == 6144) check("run1_last_wr_data", cdata_wr, 20'hF03FF);
      if (n == 6145) check("run1_done_c6145", done, 1);
      if (n == 6146) check("run1_idle_c6146", busy, 0);
      if (n == 6147) check("run1_no_restart", busy, 0);
    end
    mon_en = 1'b0;
    start  = 1'b0;
    check("run1_writes", n_wr - w0, 2048);
    check("run1_reads", n_rd - r0, 2048);
    check("run1_done_pulses", n_done - d0, 1);
    check("run1_protocol", proto_err - pe0, 0);
    check("acc0", {acc_wr[0], acc_sel[0], acc_addr[0]}, {32'd0, 32'd3, 32'd0});
    check("acc1", {acc_wr[1], acc_sel[1], acc_addr[1]}, {32'd1, 32'd5, 32'd0});
    check("acc2", {acc_wr[2], acc_sel[2], acc_addr[2]}, {32'd0, 32'd4, 32'd0});
    check("l2_0", mem_l2[0], 20'h00000);
    check("l2_1", mem_l2[1], 20'hF0000);
    check("l2_2046", mem_l2[2046], 20'h003FF);
    check("l2_2047", mem_l2[2047], 20'hF03FF);
    check_l2("run1_l2_all");

    // Run 2 aborted by reset in cycle 1500.
    w0 = n_wr; pe0 = proto_err;
    base = cyc; mon_en = 1'b1; start = 1'b1;
    for (int n = 1; n <= 1500; n++) begin
      step();
      start = 1'b0;
      if (n == 1500) begin
        reset  = 1'b0;
        mon_en = 1'b0;
      end
    end
    check("abort_writes_before", n_wr - w0, 500);
    check("abort_protocol", proto_err - pe0, 0);
    s0 = stray;
    step();
    check_zero_outputs("abort");
    reset = 1'b1;
    repeat (3) step();
    check("abort_no_strobes", stray - s0, 0);

    // Run 3 from scratch with start held high: rerun after one idle cycle.
    d0 = n_done; pe0 = proto_err;
    base = cyc; mon_en = 1'b1; start = 1'b1;
    for (int n = 1; n <= 6150; n++) begin
      step();
      if (n == 1)    check("run3_first_rd", {crd, csel, caddr_rd}, {1'b1, 3'd3, 12'h000});
      if (n == 6145) check("run3_done_c6145", done, 1);
      if (n == 6146) begin
        check("run3_busy_gap", busy, 0);
        base = base + 6146;
      end
      if (n == 6147) check("run4_restart_rd", {busy, crd, csel, caddr_rd}, {1'b1, 1'b1, 3'd3, 12'h000});
      if (n == 6150) begin
        reset  = 1'b0;
        mon_en = 1'b0;
        start  = 1'b0;
      end
    end
    step();
    check("final_reset_busy", busy, 0);
    reset = 1'b1;
    repeat (2) step();
    check("run3_protocol", proto_err - pe0, 0);
    check("run3_done_pulses", n_done - d0, 1);
    check_l2("run3_l2_all");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_flatten.md
# l2_flatten

Layer-2 flatten stage, directly downstream of the CONV convolution/max-pool engine. Once both 32x32 layer-1 max-pool maps (kernel 0 and kernel 1) are in memory, it reads them back and writes one interleaved 2048-entry layer-2 vector: element i of kernel 0 goes to address 2i, and element i of kernel 1 goes to address 2i+1. It shares the CONV-side memory bus: one csel, one read port and one write port.

## Interface
Parameters:
- N_PIX, 1024: elements per layer-1 map (32x32).
- SEL_K0, 3'b011: csel of the layer-1 kernel-0 map.
- SEL_K1, 3'b100: csel of the layer-1 kernel-1 map.
- SEL_L2, 3'b101: csel of the layer-2 output memory.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset. reset=0 at a rising edge resets the block.
- start  in  1  run request; sampled only in IDLE.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse after the last write.
- crd  out  1  memory read strobe.
- caddr_rd  out  12  read address; bits [11:10] are always 0.
- cdata_rd  in  20  read data, valid in the cycle after the RD cycle.
- cwr  out  1  memory write strobe.
- caddr_wr  out  12  write address.
- cdata_wr  out  20  write data.
- csel  out  3  memory select, shared by reads and writes.

## Operation
- FSM states: IDLE, RD, CAP, WR, DONE.
  - IDLE: start=1 -> RD; otherwise stay.
  - RD -> CAP -> WR unconditionally.
  - WR: if j==2*N_PIX-1 -> DONE; otherwise j<=j+1 and -> RD.
  - DONE -> IDLE.
- Counter j, 11 bits, 0..2047, cleared on entry from IDLE. Derived fields: i=j[10:1] (element index) and k=j[0] (kernel).
- RD: crd=1, csel=(k ? SEL_K1 : SEL_K0), caddr_rd={2'b00,i}.
- CAP:
  - csel and caddr_rd hold their RD values; crd=0.
  - cdata_rd is captured into a 20-bit data register at the end of CAP.
- WR: cwr=1, csel=SEL_L2, caddr_wr={1'b0,j} (= 2i+k), cdata_wr=data register.
- Data passes through bit-exact: no sign handling, no rounding, no clamping.
- Never drive crd and cwr high in the same cycle. csel is never driven with two values in one cycle.
- start while busy is ignored (it is sampled only in IDLE).
- If start is still high in the IDLE cycle after DONE, a new run begins and rewrites all 2048 entries.
- Outputs are decoded from the state, j and the data register. No output depends combinationally on start or cdata_rd.

## Timing
- Reset (reset=0 at an edge):
  - Next cycle: state=IDLE, j=0, data register=0.
  - busy=0, done=0, crd=0, cwr=0, csel=0, caddr_rd=0, caddr_wr=0, cdata_wr=0.
- Reset mid-run aborts immediately. No write strobe follows the reset edge. A later start restarts from j=0.
- Idle values: crd=0, cwr=0, csel=0. caddr_wr and cdata_wr hold their last values (0 after reset).
- Cycle numbering: start sampled at edge E0; cycle n follows edge E(n-1).
- Element j: RD in cycle 1+3j, CAP in cycle 2+3j, WR in cycle 3+3j.
- First write in cycle 3 (j=0). Last write in cycle 6144 (j=2047).
- done=1 only in cycle 6145. IDLE in cycle 6146.
- busy=1 in cycles 1..6145 (whole RD/CAP/WR/DONE span), 0 in IDLE.
- Throughput: 3 cycles per element, 6145 cycles from start edge to done.
- Memory model: cdata_rd reflects the address driven (with crd=1 and csel) in the previous cycle. A write is committed at the end of the cycle in which cwr=1.

## Test plan
- Reset values: hold reset=0 for 3 cycles with start=1 -> all outputs 0, busy=0, and no crd/cwr pulses.
- Full run: preload L1 k0[i]=20'h00000+i and k1[i]=20'hF0000+i, pulse start.
  - L2[2i]=i and L2[2i+1]=20'hF0000+i for all i.
  - done in cycle 6145 exactly; 2048 writes in total.
- Address/select check, same run:
  - First three accesses: read csel=3 addr 0; write csel=5 addr 0; read csel=4 addr 0.
  - Write j=2047 uses caddr_wr=12'h7FF. crd and cwr are never both high.
- Start while busy: extra start pulses in cycles 10, 3000 and 6145 -> no effect; exactly one done pulse.
- Reset mid-run: reset=0 at cycle 1500.
  - Next cycle: outputs 0, no further cwr.
  - New start rewrites from j=0 and completes 6145 cycles later.
- Start held high: after DONE, IDLE sees start=1 -> second run begins; busy low for exactly one cycle (6146).
